// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage restoring divider: widths, FSM encodings
// and handshake levels.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider request/result bundle.
// EX raises start_i with operands and holds it until it sees ready_o=1; the
// result stays valid while start_i remains high, and dropping start_i releases it.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem,dvd} left, trial-subtract the divisor
// and shift the resulting quotient bit into the low end of dvd.
module div_unit_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] dvd_nxt
);

  logic [W:0] trial;
  logic [W:0] diff;

  // rem < divisor keeps trial below 2*divisor, so diff[W] is exactly the borrow.
  always_comb begin
    trial = {rem, dvd[W-1]};
    diff  = trial - {1'b0, divisor};
    if (!diff[W]) begin
      rem_nxt = diff[W-1:0];
      dvd_nxt = {dvd[W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[W-1:0];
      dvd_nxt = {dvd[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU: one quotient bit per cycle on magnitudes, sign fix at
// the end, result {remainder, quotient} held while EX keeps start_i high.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus,
  output logic [1:0] state
);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] divisor;
  logic              sign1;
  logic              sign2;
  logic              signed_r;

  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] dvd_nxt;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;

  div_unit_step #(.W(DATA_W)) u_step (
    .rem     (rem),
    .dvd     (dvd),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt)
  );

  // Magnitudes wrap mod 2^DATA_W, so the most negative value maps to itself.
  always_comb begin
    abs1  = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs2  = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    q_fix = (signed_r && (sign1 ^ sign2)) ? -dvd : dvd;
    r_fix = (signed_r && sign1) ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DivFree;
      cnt          <= '0;
      rem          <= '0;
      dvd          <= '0;
      divisor      <= '0;
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      signed_r     <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          bus.ready_o  <= DivResultNotReady;
          bus.result_o <= '0;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              rem      <= '0;
              dvd      <= abs1;
              divisor  <= abs2;
              sign1    <= bus.opdata1_i[DATA_W-1];
              sign2    <= bus.opdata2_i[DATA_W-1];
              signed_r <= bus.signed_div_i;
            end
          end
        end
        DivByZero: begin
          bus.result_o <= '0;
          bus.ready_o  <= DivResultReady;
          state        <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state <= DivFree;
          end else if (cnt != CNT_W'(DATA_W)) begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt + 1'b1;
          end else begin
            bus.result_o <= {r_fix, q_fix};
            bus.ready_o  <= DivResultReady;
            state        <= DivEnd;
          end
        end
        DivEnd: begin
          // annul_i is deliberately ignored here: EX already owns the result.
          if (bus.start_i == DivStop) begin
            state        <= DivFree;
            bus.ready_o  <= DivResultNotReady;
            bus.result_o <= '0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of reference quotients and
// remainders, plus latency, annul, reset and hold checks.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int DATA_W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] state;

  div_unit_if #(.DATA_W(DATA_W)) bus ();

  div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = {32'd0, a} / {32'd0, b};
      r = {32'd0, a} % {32'd0, b};
    end
    return {r[31:0], q[31:0]};
  endfunction

  // driver: issue one request, follow it to END, hold, then release
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic mutate);
    int k;
    int lat;
    logic [63:0] exp_v;
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    exp_q.push_back(model(s, a, b));
    // ready is set by edge T+1 (zero) or T+33 (normal): seen by EX at T+2 / T+34
    lat = (b == 32'd0) ? 1 : DATA_W + 1;
    @(posedge clk);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      #1;
      if (mutate && k == 3) begin
        bus.opdata1_i = ~a;
        bus.opdata2_i = b ^ 32'h5;
      end
    end while (!bus.ready_o && k < 60);
    check("latency", 64'(k), 64'(lat));
    exp_v = exp_q.pop_front();
    if (bus.ready_o) begin
      check("result", bus.result_o, exp_v);
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("hold_ready", 64'(bus.ready_o), 64'd1);
        check("hold_result", bus.result_o, exp_v);
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("release_ready", 64'(bus.ready_o), 64'd0);
    check("release_result", bus.result_o, 64'd0);
    check("release_state", 64'(state), 64'(DivFree));
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'(DivFree));
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 3, 1'b0);
    check("divu_100_7_const", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1, 1'b0);
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 1, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0);
    run_div(1'b1, 32'h12345678, 32'h00000000, 5, 1'b0);
    run_div(1'b0, 32'hDEADBEEF, 32'h00001234, 1, 1'b1);
    run_div(1'b1, 32'h80000001, 32'h00000003, 1, 1'b1);

    // annul mid-flight
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    check("annul_pre_state", 64'(state), 64'(DivOn));
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_state", 64'(state), 64'(DivFree));
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("annul_quiet", 64'(bus.ready_o), 64'd0);
    end
    run_div(1'b0, 32'd9, 32'd3, 1, 1'b0);

    // reset mid-flight
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hCAFEF00D;
    bus.opdata2_i    = 32'd77;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", 64'(state), 64'(DivFree));
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom >> $urandom_range(0, 31);
      run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
